// File: rtl/parity_pkg.sv
// Shared constants and helpers for the parity streaming blocks.
//   PAR_EVEN / PAR_ODD : parity mode selectors for the ODD parameter
//   cnt_width()        : width of a counter that must hold 0..max_words
package parity_pkg;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one data word to a single parity bit.
// Ports:
//   data_i [WIDTH-1:0] : word to reduce
//   par_o              : XOR of all bits of data_i (even parity of the word)
module parity_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             par_o
);

    // Running XOR chain; the last tap is the reduction of the whole word.
    logic [WIDTH-1:0] chain;

    assign chain[0] = data_i[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign chain[gi] = chain[gi-1] ^ data_i[gi];
        end
    endgenerate

    assign par_o = chain[WIDTH-1];

endmodule

// File: rtl/parity_stream.sv
// Streaming parity generator for multi-word frames.
// Words arrive on a valid/ready channel; parity accumulates up to and
// including the word flagged in_last (or the MAX_WORDS-th word, which
// force-terminates the frame). One result per frame is presented on a
// valid/ready output channel.
//
// Optional checker: define PARITY_CHECK_EN to add in_par / out_err, which
// flag a mismatch between the computed parity and the received parity bit
// sampled with the final word.
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : input handshake
//   in_data [WIDTH-1:0] : data word
//   in_last             : final word of frame
//   in_par              : received parity (PARITY_CHECK_EN only)
//   out_valid/out_ready : result handshake
//   out_par             : frame parity bit
//   out_words [CW-1:0]  : words in the frame, 1..MAX_WORDS
//   out_ovf             : frame force-terminated at MAX_WORDS
//   out_err             : out_par != in_par (PARITY_CHECK_EN only)
module parity_stream
    import parity_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int ODD       = PAR_ODD,
    parameter  int MAX_WORDS = 16,
    localparam int CW        = cnt_width(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
`ifdef PARITY_CHECK_EN
    input  logic             in_par,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par,
    output logic [CW-1:0]    out_words,
    output logic             out_ovf
`ifdef PARITY_CHECK_EN
    ,
    output logic             out_err
`endif
);

    // The FSM state is the result-valid flag itself.
    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);

    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic          par_q, par_d;
    logic [CW-1:0] words_q, words_d;
    logic          ovf_q, ovf_d;

    logic word_par;
    logic accept;
    logic at_limit;
    logic final_word;
    logic frame_x;
    logic frame_par;

    parity_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .data_i (in_data),
        .par_o  (word_par)
    );

    // A held result blocks input so nothing can overwrite it.
    assign in_ready   = (state_q == ST_ACC) || out_ready;
    assign accept     = in_valid && in_ready;
    assign at_limit   = (cnt_q == LAST_CNT);
    assign final_word = in_last || at_limit;
    assign frame_x    = acc_q ^ word_par;
    assign frame_par  = (ODD != PAR_EVEN) ? ~frame_x : frame_x;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        par_d   = par_q;
        words_d = words_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_DONE: if (out_ready) state_d = ST_ACC;
            default: state_d = state_q;
        endcase

        if (accept) begin
            if (final_word) begin
                // New result loads even when the previous one is being
                // consumed this same cycle, keeping single-word frames at
                // full rate.
                state_d = ST_DONE;
                par_d   = frame_par;
                words_d = cnt_q + CW'(1);
                ovf_d   = !in_last && at_limit;
                acc_d   = 1'b0;
                cnt_d   = '0;
            end else begin
                acc_d = frame_x;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_ACC;
            par_q   <= 1'b0;
            words_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            par_q   <= par_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = state_q[0];
    assign out_par   = par_q;
    assign out_words = words_q;
    assign out_ovf   = ovf_q;

`ifdef PARITY_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && final_word) err_d = frame_par ^ in_par;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign out_err = err_q;
`endif

endmodule

// File: tb/tb_parity_stream.sv
// Self-checking bench for parity_stream.
// Instance A: WIDTH=8, ODD=1, MAX_WORDS=4 (table vectors, hand sequences,
// randomized run against a frame-level reference model).
// Instance B: WIDTH=8, ODD=0, MAX_WORDS=16 (even-parity frames).
module tb_parity_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A signals
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_in_data  = 8'h00;
    logic       a_in_last  = 1'b0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b1;
    logic       a_out_par;
    logic [2:0] a_out_words;
    logic       a_out_ovf;
`ifdef PARITY_CHECK_EN
    logic       a_in_par = 1'b0;
    logic       a_out_err;
    logic       b_in_par = 1'b0;
    logic       b_out_err;
`endif

    // Instance B signals
    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_in_data  = 8'h00;
    logic       b_in_last  = 1'b0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b1;
    logic       b_out_par;
    logic [4:0] b_out_words;
    logic       b_out_ovf;

    parity_stream #(.WIDTH(8), .ODD(1), .MAX_WORDS(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_last   (a_in_last),
`ifdef PARITY_CHECK_EN
        .in_par    (a_in_par),
        .out_err   (a_out_err),
`endif
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_par   (a_out_par),
        .out_words (a_out_words),
        .out_ovf   (a_out_ovf)
    );

    parity_stream #(.WIDTH(8), .ODD(0), .MAX_WORDS(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
`ifdef PARITY_CHECK_EN
        .in_par    (b_in_par),
        .out_err   (b_out_err),
`endif
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_par   (b_out_par),
        .out_words (b_out_words),
        .out_ovf   (b_out_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       exp_valid;
        logic       exp_par;
        logic [2:0] exp_words;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [12];

    // Reference model state for the randomized run
    logic [7:0] frame_q [$];
    logic       m_pend;
    logic       m_par;
    int         m_words;
    logic       m_ovf;
    logic       m_err;

    initial begin
        // Single-word, two-word and overflow frames on instance A (odd, MAX=4)
        vecs[0]  = '{8'h0F, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        vecs[1]  = '{8'h07, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[2]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[3]  = '{8'h02, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[4]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[5]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[6]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[7]  = '{8'h01, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1};
        vecs[8]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[9]  = '{8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[10] = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
        vecs[11] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};

        // ---- reset values ----
        #2;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_par",   a_out_par,   0);
        chk("rst_out_words", a_out_words, 0);
        chk("rst_out_ovf",   a_out_ovf,   0);
        chk("rst_in_ready",  a_in_ready,  1);
        #5 rst = 1'b0;

        // ---- table vectors, out_ready held high ----
        a_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = vecs[i].data;
            a_in_last  = vecs[i].last;
            #1;
            chk("tbl_in_ready", a_in_ready, 1);
            step();
            $display("vec %0d: data=%02h last=%0b -> valid=%0b par=%0b words=%0d ovf=%0b",
                     i, vecs[i].data, vecs[i].last, a_out_valid, a_out_par, a_out_words, a_out_ovf);
            chk("tbl_out_valid", a_out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk("tbl_out_par",   a_out_par,   vecs[i].exp_par);
                chk("tbl_out_words", a_out_words, vecs[i].exp_words);
                chk("tbl_out_ovf",   a_out_ovf,   vecs[i].exp_ovf);
            end
        end
        a_in_valid = 1'b0;
        step();
        chk("drain_out_valid", a_out_valid, 0);

        // ---- backpressure ----
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h03;
        a_in_last   = 1'b1;
        step();
        chk("bp_first_valid", a_out_valid, 1);
        a_in_data = 8'h80;
        for (int k = 0; k < 3; k++) begin
            step();
            $display("bp hold %0d: in_ready=%0b valid=%0b par=%0b words=%0d",
                     k, a_in_ready, a_out_valid, a_out_par, a_out_words);
            chk("bp_in_ready",  a_in_ready,  0);
            chk("bp_hold_valid", a_out_valid, 1);
            chk("bp_hold_par",   a_out_par,   1);
            chk("bp_hold_words", a_out_words, 1);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_in_ready, 1);
        step();
        a_in_valid = 1'b0;
        $display("bp release: valid=%0b par=%0b words=%0d", a_out_valid, a_out_par, a_out_words);
        chk("bp_new_valid", a_out_valid, 1);
        chk("bp_new_par",   a_out_par,   0);
        chk("bp_new_words", a_out_words, 1);
        step();
        chk("bp_idle_valid", a_out_valid, 0);

`ifdef PARITY_CHECK_EN
        // ---- checker ----
        a_in_valid = 1'b1;
        a_in_data  = 8'h03;
        a_in_last  = 1'b1;
        a_in_par   = 1'b1;
        step();
        chk("chk_err_match", a_out_err, 0);
        a_in_par = 1'b0;
        step();
        chk("chk_err_mismatch", a_out_err, 1);
        a_in_valid = 1'b0;
        step();
`endif

        // ---- reset mid-frame ----
        a_in_valid = 1'b1;
        a_in_data  = 8'h01;
        a_in_last  = 1'b0;
        step();
        a_in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rmf_out_valid", a_out_valid, 0);
        chk("rmf_out_par",   a_out_par,   0);
        chk("rmf_out_words", a_out_words, 0);
        chk("rmf_in_ready",  a_in_ready,  1);
        #1 rst = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = 8'h00;
        a_in_last  = 1'b1;
        step();
        a_in_valid = 1'b0;
        $display("reset mid-frame: valid=%0b par=%0b words=%0d", a_out_valid, a_out_par, a_out_words);
        chk("rmf_valid", a_out_valid, 1);
        chk("rmf_par",   a_out_par,   1);
        chk("rmf_words", a_out_words, 1);

        // ---- reset mid-result ----
        a_out_ready = 1'b0;
        step();
        chk("rmr_pending", a_out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rmr_dropped", a_out_valid, 0);
        #1 rst = 1'b0;
        step();
        chk("rmr_stays_clear", a_out_valid, 0);

        // ---- instance B: even parity, two-word frame ----
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h01;
        b_in_last   = 1'b0;
        step();
        chk("even_mid_valid", b_out_valid, 0);
        b_in_data = 8'h02;
        b_in_last = 1'b1;
        step();
        $display("even frame: valid=%0b par=%0b words=%0d", b_out_valid, b_out_par, b_out_words);
        chk("even_valid", b_out_valid, 1);
        chk("even_par",   b_out_par,   0);
        chk("even_words", b_out_words, 2);
        b_in_data = 8'h07;
        step();
        b_in_valid = 1'b0;
        chk("even_par_odd_ones", b_out_par,   1);
        chk("even_words_one",    b_out_words, 1);
        chk("even_ovf",          b_out_ovf,   0);

        // ---- randomized run against frame-level model ----
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        frame_q.delete();
        m_pend  = 1'b0;
        m_par   = 1'b0;
        m_words = 0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic exp_ready;
            logic accepted;
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = 8'($urandom);
            a_in_last   = ($urandom_range(0, 3) == 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
`ifdef PARITY_CHECK_EN
            a_in_par    = 1'($urandom);
`endif
            #1;
            exp_ready = !m_pend || a_out_ready;
            chk("rnd_in_ready",  a_in_ready,  exp_ready);
            chk("rnd_out_valid", a_out_valid, m_pend);
            if (m_pend) begin
                chk("rnd_out_par",   a_out_par,   m_par);
                chk("rnd_out_words", a_out_words, m_words);
                chk("rnd_out_ovf",   a_out_ovf,   m_ovf);
`ifdef PARITY_CHECK_EN
                chk("rnd_out_err",   a_out_err,   m_err);
`endif
                if (a_out_ready) begin
                    $display("rnd cyc %0d: result par=%0b words=%0d ovf=%0b consumed",
                             cyc, m_par, m_words, m_ovf);
                    m_pend = 1'b0;
                end
            end
            accepted = a_in_valid && exp_ready;
            if (accepted) begin
                frame_q.push_back(a_in_data);
                if (a_in_last || frame_q.size() == 4) begin
                    int ones;
                    ones = 0;
                    foreach (frame_q[j]) ones += $countones(frame_q[j]);
                    // odd parity: data ones plus parity bit must be odd
                    m_par   = ((ones % 2) == 0);
                    m_words = frame_q.size();
                    m_ovf   = !a_in_last;
`ifdef PARITY_CHECK_EN
                    m_err   = m_par ^ a_in_par;
`endif
                    m_pend  = 1'b1;
                    frame_q.delete();
                end
            end
            step();
        end
        a_in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/parity_stream.md
# parity_stream

Streaming, parametrised parity generator for multi-word frames. Words of `WIDTH` bits arrive on a valid/ready input channel. Parity accumulates over every word up to and including the word flagged `in_last`. One result per frame is then presented on a valid/ready output channel. The block sits between a packet source and a link serializer; an optional checker compares the computed parity against a received parity bit.

## Interface
- `WIDTH`, default 8: data word width, ≥1.
- `ODD`, default 1: 1 = odd parity, so the output bit makes data ones + parity odd (bit = XNOR of all data bits). 0 = even parity (bit = XOR of all data bits).
- `MAX_WORDS`, default 16: maximum frame length in words, ≥1. `CW = $clog2(MAX_WORDS+1)`.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `in_valid`, in, 1: input word present.
- `in_ready`, out, 1: block accepts a word this cycle.
- `in_data`, in, `WIDTH`: data word.
- `in_last`, in, 1: word is the final word of its frame.
- `in_par`, in, 1: received parity bit, sampled with the last word. Present only with `PARITY_CHECK_EN`.
- `out_valid`, out, 1: frame result present.
- `out_ready`, in, 1: consumer takes the result.
- `out_par`, out, 1: frame parity bit.
- `out_words`, out, `CW`: number of words in the frame, 1..`MAX_WORDS`.
- `out_ovf`, out, 1: frame was force-terminated at `MAX_WORDS`.
- `out_err`, out, 1: `out_par` ≠ `in_par`. Present only with `PARITY_CHECK_EN`.

## Operation
- **Accept rule:** a word is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`, a combinational function of registered state and `out_ready`.
- **Accumulator:** `acc` is a 1-bit running XOR; `cnt` (`CW` bits) is the word count.
  - On accept of a non-final word: `acc <= acc ^ (^in_data)`, `cnt <= cnt + 1`.
- **Final word:** a word is final if `in_last`, or if `cnt == MAX_WORDS-1`.
  - On accept of a final word, register the result:
    - `x = acc ^ (^in_data)`
    - `out_par = ODD ? ~x : x`
    - `out_words = cnt + 1`
    - `out_ovf = !in_last && (cnt == MAX_WORDS-1)`
    - `out_err = out_par ^ in_par` (checker builds only)
  - Set `out_valid`, and clear `acc` and `cnt` in the same cycle.
- **Overflow:** after a forced termination, the following words start a new frame. No word is dropped.
- **Result handshake:** `out_valid && out_ready` consumes the result; `out_valid` clears unless a new final word is accepted the same cycle, in which case the new result loads and `out_valid` stays 1.
- **Hold:** while `out_valid && !out_ready`, all result outputs hold stable and `in_ready = 0`.
- **FSM, two states, encoded by `out_valid`:**
  - ACC → ACC on a non-final accept.
  - ACC → DONE on a final accept.
  - DONE → ACC on `out_ready` with no final accept.
  - DONE → DONE on `out_ready` with a final accept.
- **`MAX_WORDS = 1`:** every word is final. `out_ovf = !in_last`.

## Timing
- **Reset values:** `acc = 0`, `cnt = 0`, `out_valid = 0`, `out_par = 0`, `out_words = 0`, `out_ovf = 0`, `out_err = 0`. Consequently `in_ready = 1` out of reset.
- **Latency:** `out_valid` rises on the clock edge that accepts the final word, so the result is visible 1 cycle after the accept.
- **Throughput:** one word per cycle, including back-to-back single-word frames, when `out_ready` is held high.
- **Reset mid-frame:** the partial frame is discarded with no output, and the next accepted word starts a fresh frame.
- **Reset mid-result:** a pending result is dropped.

## Configuration
- Macro `PARITY_CHECK_EN`.
- **Defined:** ports `in_par` and `out_err` exist, and the checker logic is built.
- **Undefined:** neither port exists and no checker logic is built. All other behaviour is identical.

## Structure
- **`parity_pkg`:**
  - `PAR_EVEN = 0`, `PAR_ODD = 1` mode constants.
  - Function `cnt_width(max_words)` returning `$clog2(max_words+1)`.
- **Sub-module `parity_reduce #(WIDTH)`:** combinational XOR-reduce of `in_data` to 1 bit, reused by later checkers.

## Test plan
- **Single-word frame, odd parity:** `WIDTH=8`, `ODD=1`, `out_ready=1`; word `8'h0F` with `last` → next cycle `out_valid=1`, `out_par=1`, `out_words=1`, `out_ovf=0`. Word `8'h07` → `out_par=0`.
- **Two-word frame, both modes:** words `8'h01` then `8'h02` (`last`) → `out_par=1`, `out_words=2`. Repeat with `ODD=0` → `out_par=0`.
- **Backpressure:** hold `out_ready=0` for 3 cycles after a result while `in_valid=1` → `in_ready=0`, result stable, no word lost. Raise `out_ready` → the next word is accepted the same cycle.
- **Overflow:** `MAX_WORDS=4`, six words `8'h01` with no `last` → first result `out_words=4`, `out_ovf=1`, `out_par=1`. Then a word with `last` ends a 3-word frame → `out_words=3`, `out_ovf=0`, `out_par=0`.
- **Checker (`PARITY_CHECK_EN`):** frame `8'h03` with `in_par=1` → `out_err=0`. Same word with `in_par=0` → `out_err=1`.
- **Reset mid-frame:** accept `8'h01`, assert `rst`, release, then send `8'h00` with `last` → `out_par=1`, `out_words=1`. All outputs are 0 during reset.
